csam_seq_mult: RTL and testbench



---
 rtl/csam_seq_mult.sv | 174 +++++++++++++++++
 tb/tb_csam_seq_mult.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/csam_seq_mult.sv
// ---------------------------------------------------------------------------
// csam_seq_mult
//   Multi-cycle unsigned XW x YW multiplier built around a single 8x4
//   carry-save array multiplier (csam_8x4). Operands are split into 8-bit
//   multiplicand chunks and 4-bit multiplier nibbles. One chunk/nibble pair
//   is multiplied per cycle, and the shifted partial product is added into a
//   wide accumulator. Each operation takes NX*NY accumulate cycles.
//
// Ports (top):
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   in_valid   in   operand pair a/b valid
//   in_ready   out  operands accepted (IDLE only)
//   a          in   XW-bit unsigned multiplicand
//   b          in   YW-bit unsigned multiplier
//   out_valid  out  p holds the final product (DONE only)
//   out_ready  in   consumer takes p
//   p          out  XW+YW-bit product (the registered accumulator)
//   busy       out  high while RUN or DONE
//
// csam_8x4 ports:
//   i_x  in  8-bit multiplicand chunk
//   i_y  in  4-bit multiplier nibble
//   o_z  out 12-bit product
// ---------------------------------------------------------------------------

module csam_8x4 (
  input  logic [7:0]  i_x,
  input  logic [3:0]  i_y,
  output logic [11:0] o_z
);

  // Rows of full adders keep sum and carry separate. Row j adds the partial
  // product x & y[j] to the previous row's sums (shifted down one column)
  // and carries. Only the final merge uses a carry-propagate adder.
  function automatic logic [11:0] csam(input logic [7:0] x, input logic [3:0] y);
    logic [7:0]  s;
    logic [7:0]  c;
    logic [7:0]  sn;
    logic [7:0]  cn;
    logic [8:0]  se;
    logic [7:0]  fin;
    logic [11:0] z;
    logic        pp;
    logic        sb;
    s    = x & {8{y[0]}};
    c    = '0;
    sn   = '0;
    cn   = '0;
    z    = '0;
    z[0] = s[0];
    for (int j = 1; j < 4; j++) begin
      se = {1'b0, s};
      for (int i = 0; i < 8; i++) begin
        pp    = x[i] & y[j];
        sb    = se[i+1];
        sn[i] = pp ^ sb ^ c[i];
        cn[i] = (pp & sb) | (pp & c[i]) | (sb & c[i]);
      end
      s    = sn;
      c    = cn;
      z[j] = s[0];
    end
    // Product fits in 12 bits, so the merge adder has no carry out.
    fin      = {1'b0, s[7:1]} + c;
    z[11:4]  = fin;
    return z;
  endfunction

  assign o_z = csam(i_x, i_y);

endmodule

module csam_seq_mult #(
  parameter int XW = 16,
  parameter int YW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XW-1:0]      a,
  input  logic [YW-1:0]      b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XW+YW-1:0]   p,
  output logic               busy
);

  localparam int NX   = XW / 8;
  localparam int NY   = YW / 4;
  localparam int N    = NX * NY;
  localparam int PW   = XW + YW;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [XW-1:0]     r_a;
  logic [YW-1:0]     r_b;
  logic [PW-1:0]     r_acc;
  logic [IDXW-1:0]   r_idx;

  int                w_xi;
  int                w_yj;
  int                w_sh;
  logic [7:0]        w_x;
  logic [3:0]        w_y;
  logic [11:0]       w_z;
  logic [PW-1:0]     w_pp;

  // Step idx walks the multiplicand chunks fastest, then the nibbles.
  always_comb begin
    w_xi = int'(r_idx) % NX;
    w_yj = int'(r_idx) / NX;
    w_sh = 8 * w_xi + 4 * w_yj;
    w_x  = r_a[8*w_xi +: 8];
    w_y  = r_b[4*w_yj +: 4];
  end

  csam_8x4 u_csam (
    .i_x (w_x),
    .i_y (w_y),
    .o_z (w_z)
  );

  assign w_pp = PW'(w_z) << w_sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc <= r_acc + w_pp;
          if (r_idx == IDXW'(N - 1)) begin
            r_idx   <= '0;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake outputs depend on state only, so reset clears them at once.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign p         = r_acc;

endmodule

// File: tb/tb_csam_seq_mult.sv
module tb_csam_seq_mult;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [7:0]  b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] p;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [23:0] p;
  } vec_t;

  vec_t vecs[6];

  csam_seq_mult #(.XW(16), .YW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands at a falling edge; the following rising edge accepts.
  task automatic start_op(input logic [15:0] ta, input logic [7:0] tb);
    @(negedge clk);
    a        = ta;
    b        = tb;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release_done();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("back_to_idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("back_to_idle_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic do_op(input string name, input logic [15:0] ta, input logic [7:0] tb,
                       input logic [23:0] tp);
    int cyc;
    start_op(ta, tb);
    wait_done(cyc);
    check({name, "_latency"}, cyc, 32'd4);
    check({name, "_p"}, {8'd0, p}, {8'd0, tp});
    release_done();
  endtask

  initial begin
    int cyc;
    logic [23:0] nom[4];
    int acc_t[2];
    int nacc;
    int nres;
    logic [23:0] b2b_exp[2];

    vecs[0] = '{a: 16'h1234, b: 8'h56, p: 24'h061D78};
    vecs[1] = '{a: 16'hFFFF, b: 8'hFF, p: 24'hFEFF01};
    vecs[2] = '{a: 16'h0000, b: 8'h00, p: 24'h000000};
    vecs[3] = '{a: 16'h00FF, b: 8'h0F, p: 24'h000EF1};
    vecs[4] = '{a: 16'hABCD, b: 8'h01, p: 24'h00ABCD};
    vecs[5] = '{a: 16'h8000, b: 8'h80, p: 24'h400000};
    nom[0] = 24'h000138;
    nom[1] = 24'h006D38;
    nom[2] = 24'h007D78;
    nom[3] = 24'h061D78;
    b2b_exp[0] = 24'h000006;
    b2b_exp[1] = 24'h001000;

    // Reset state
    #1 reset = 1'b1;
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_p", {8'd0, p}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Nominal product, accumulator per step
    start_op(16'h1234, 8'h56);
    check("nom_acc_clear", {8'd0, p}, 32'd0);
    check("nom_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("nom_acc_E%0d", k + 1), {8'd0, p}, {8'd0, nom[k]});
      check($sformatf("nom_out_valid_E%0d", k + 1), {31'd0, out_valid}, (k == 3) ? 32'd1 : 32'd0);
    end
    release_done();

    // Table of products
    for (int v = 0; v < 6; v++)
      do_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].p);

    // Zero operand; operand change during RUN is ignored
    start_op(16'h0000, 8'hAB);
    @(negedge clk);
    a        = 16'hFFFF;
    b        = 8'hFF;
    in_valid = 1'b1;
    wait_done(cyc);
    check("zero_latency", cyc, 32'd3);
    check("zero_p", {8'd0, p}, 32'd0);
    in_valid = 1'b0;
    release_done();

    // Backpressure in DONE
    start_op(16'h00FF, 8'h0F);
    wait_done(cyc);
    in_valid = 1'b1;
    a        = 16'h0001;
    b        = 8'h01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp_out_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_p_%0d", k), {8'd0, p}, 32'h000EF1);
      check($sformatf("bp_in_ready_%0d", k), {31'd0, in_ready}, 32'd0);
    end
    release_done();
    do_op("after_bp", 16'h0003, 8'h07, 24'h000015);

    // Back-to-back with out_ready held high
    out_ready = 1'b1;
    nacc = 0;
    nres = 0;
    cyc  = 0;
    acc_t[0] = 0;
    acc_t[1] = 0;
    while (nres < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        check($sformatf("b2b_p%0d", nres), {8'd0, p}, {8'd0, b2b_exp[nres]});
        nres++;
      end
      if (in_ready) begin
        if (nacc == 0) begin
          a = 16'h0002; b = 8'h03; in_valid = 1'b1;
          acc_t[0] = cyc; nacc++;
        end else if (nacc == 1) begin
          a = 16'h0100; b = 8'h10; in_valid = 1'b1;
          acc_t[1] = cyc; nacc++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_results", nres, 32'd2);
    check("b2b_spacing", acc_t[1] - acc_t[0], 32'd6);

    // Reset in the middle of RUN
    start_op(16'h1234, 8'h56);
    @(negedge clk);
    @(negedge clk);
    check("mid_acc_E2", {8'd0, p}, 32'h006D38);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_p", {8'd0, p}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_no_result", {31'd0, out_valid}, 32'd0);
    do_op("after_rst", 16'h0003, 8'h05, 24'h00000F);

    // Reset while DONE drops out_valid immediately
    start_op(16'h00FF, 8'h0F);
    wait_done(cyc);
    check("done_rst_pre", {31'd0, out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("done_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("done_rst_busy", {31'd0, busy}, 32'd0);
    check("done_rst_p", {8'd0, p}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
